// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// load/store port and the debug/loader port.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAST_C = 2'd1,
    ARB_LAST_D = 2'd2,
    ARB_LOCK_D = 2'd3
  } arb_state_t;

  localparam int STARVE_MAX_DEFAULT = 4;

  // Load/store funct3 width codes; the arbiter forwards them untouched to memory.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core vs. debug/loader, round-robin with a debug
// burst lock and a starvation limit that forces a core grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int AW         = 12
) (
  input  logic          clk,
  input  logic          n_rst,

  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [2:0]    c_funct3,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [2:0]    d_funct3,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,

  output logic          m_wr,
  output logic          m_rd,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [2:0]    m_funct3,
  input  logic [31:0]   m_rdata,

  output logic          core_stall
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          c_pend_q, c_pend_d;
  logic          d_pend_q, d_pend_d;

  logic          starved;
  logic          pick_c, pick_d;

  assign starved = c_req && (starve_cnt_q == STARVE_LIMIT);

  // Grant selection and next state; the starvation limit overrides the lock.
  always_comb begin
    pick_c  = 1'b0;
    pick_d  = 1'b0;
    state_d = state_q;

    if (starved) begin
      pick_c = 1'b1;
    end else begin
      case (state_q)
        ARB_LOCK_D: pick_d = d_req;
        ARB_LAST_C: begin
          if (d_req) pick_d = 1'b1;
          else       pick_c = c_req;
        end
        default: begin
          if (c_req) pick_c = 1'b1;
          else       pick_d = d_req;
        end
      endcase
    end

    if (pick_c) begin
      if (!(state_q == ARB_LOCK_D && d_lock)) state_d = ARB_LAST_C;
    end else if (pick_d) begin
      state_d = d_lock ? ARB_LOCK_D : ARB_LAST_D;
    end else if (state_q == ARB_LOCK_D && !d_lock && !d_req) begin
      state_d = ARB_LAST_D;
    end
  end

  // Grants are masked while in reset so nothing reaches memory.
  assign c_gnt      = n_rst & pick_c;
  assign d_gnt      = n_rst & pick_d;
  assign core_stall = c_req & ~c_gnt;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (c_gnt || !c_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && starve_cnt_q != STARVE_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    c_pend_d = c_gnt & ~c_we;
    d_pend_d = d_gnt & ~d_we;
  end

  always_comb begin
    m_wr     = 1'b0;
    m_rd     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_funct3 = '0;
    if (c_gnt) begin
      m_wr     = c_we;
      m_rd     = ~c_we;
      m_addr   = c_addr;
      m_wdata  = c_wdata;
      m_funct3 = c_funct3;
    end else if (d_gnt) begin
      m_wr     = d_we;
      m_rd     = ~d_we;
      m_addr   = d_addr;
      m_wdata  = d_wdata;
      m_funct3 = d_funct3;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      c_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      c_pend_q     <= c_pend_d;
      d_pend_q     <= d_pend_d;
    end
  end

  assign c_rvalid = c_pend_q;
  assign d_rvalid = d_pend_q;
  assign c_rdata  = c_pend_q ? m_rdata : 32'h0;
  assign d_rdata  = d_pend_q ? m_rdata : 32'h0;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!n_rst)
    !(c_gnt && d_gnt));
  strobe_onehot_a: assert property (@(posedge clk) disable iff (!n_rst)
    !(m_wr && m_rd));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed literal scenarios plus a
// randomized run checked every cycle against a behavioural arbitration model.
module tb_dmem_arbiter;

  localparam int SM = 4;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          c_req, c_we;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [2:0]    c_funct3;
  logic          c_gnt, c_rvalid;
  logic [31:0]   c_rdata;
  logic          d_req, d_we, d_lock;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [2:0]    d_funct3;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          m_wr, m_rd;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [2:0]    m_funct3;
  logic [31:0]   m_rdata;
  logic          core_stall;

  dmem_arbiter #(.STARVE_MAX(SM), .AW(AW)) dut (
    .clk(clk), .n_rst(n_rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_funct3(c_funct3), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_funct3(d_funct3), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_funct3(m_funct3), .m_rdata(m_rdata), .core_stall(core_stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: who owns the bus, who won last, how long core has waited.
  bit debug_owns_bus = 0;
  int last_winner    = 0;   // 0 nobody, 1 core, 2 debug
  int core_wait      = 0;
  bit core_read_out  = 0;
  bit dbg_read_out   = 0;
  bit exp_c_gnt      = 0;
  bit exp_d_gnt      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit ec, ed;
    logic [AW-1:0] ea;
    logic [31:0] ewd, ecr, edr;
    logic [2:0] ef;
    bit ewr, erd;
    ec = 0; ed = 0; ea = '0; ewd = '0; ef = '0; ewr = 0; erd = 0;
    if (!n_rst) begin
      debug_owns_bus = 0; last_winner = 0; core_wait = 0;
      core_read_out = 0; dbg_read_out = 0;
    end else begin
      if (c_req && core_wait == SM)       ec = 1;
      else if (debug_owns_bus)            ed = d_req;
      else if (c_req && d_req)            begin if (last_winner == 1) ed = 1; else ec = 1; end
      else                                begin ec = c_req; ed = d_req; end
      if (ec) begin ewr = c_we; erd = !c_we; ea = c_addr; ewd = c_wdata; ef = c_funct3; end
      if (ed) begin ewr = d_we; erd = !d_we; ea = d_addr; ewd = d_wdata; ef = d_funct3; end
    end
    ecr = core_read_out ? m_rdata : 32'h0;
    edr = dbg_read_out  ? m_rdata : 32'h0;

    chk("c_gnt", c_gnt, ec);
    chk("d_gnt", d_gnt, ed);
    chk("both_gnt", c_gnt & d_gnt, 0);
    chk("both_strobe", m_wr & m_rd, 0);
    chk("m_wr", m_wr, ewr);
    chk("m_rd", m_rd, erd);
    chk("m_addr", m_addr, ea);
    chk("m_wdata", m_wdata, ewd);
    chk("m_funct3", m_funct3, ef);
    chk("c_rvalid", c_rvalid, core_read_out);
    chk("d_rvalid", d_rvalid, dbg_read_out);
    chk("c_rdata", c_rdata, ecr);
    chk("d_rdata", d_rdata, edr);
    chk("core_stall", core_stall, c_req && !ec);

    if (n_rst) begin
      if (ec) begin
        if (!(debug_owns_bus && d_lock)) begin debug_owns_bus = 0; last_winner = 1; end
      end else if (ed) begin
        debug_owns_bus = d_lock; last_winner = 2;
      end else if (debug_owns_bus && !d_lock && !d_req) begin
        debug_owns_bus = 0; last_winner = 2;
      end
      if (ec || !c_req)  core_wait = 0;
      else if (ed)       core_wait = core_wait + 1;
      core_read_out = ec && !c_we;
      dbg_read_out  = ed && !d_we;
    end
    exp_c_gnt = ec;
    exp_d_gnt = ed;
  endtask

  always @(negedge clk) checkOutput();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    step();
    n_rst = 0; c_req = 1; d_req = 0; d_lock = 0;
    mid();
    chk("rst_core_stall", core_stall, 1);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_m_rd", m_rd, 0);
    step();
    n_rst = 1; c_req = 0;
  endtask

  // Random requests that respect hold-until-grant; occasional async reset pulses.
  task automatic applyStimulus();
    n_rst = ($urandom_range(0, 299) != 0);
    if (exp_c_gnt || !c_req) begin
      c_req    = ($urandom_range(0, 99) < 60);
      c_we     = $urandom_range(0, 1);
      c_addr   = AW'($urandom);
      c_wdata  = $urandom;
      c_funct3 = 3'($urandom);
    end
    if (exp_d_gnt || !d_req) begin
      d_req    = ($urandom_range(0, 99) < 55);
      d_we     = $urandom_range(0, 1);
      d_addr   = AW'($urandom);
      d_wdata  = $urandom;
      d_funct3 = 3'($urandom);
    end
    if ($urandom_range(0, 99) < 30) d_lock = $urandom_range(0, 1);
    m_rdata = $urandom;
  endtask

  initial begin
    int dcount;
    bit want_c;
    n_rst = 0; c_req = 1; c_we = 0; c_addr = '0; c_wdata = '0; c_funct3 = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
    m_rdata = '0;
    mid();
    chk("reset_core_stall", core_stall, 1);
    chk("reset_c_gnt", c_gnt, 0);
    chk("reset_c_rvalid", c_rvalid, 0);

    // Core read 0x010, response next cycle.
    step();
    n_rst = 1; c_req = 1; c_we = 0; c_addr = 12'h010; c_funct3 = 3'd2;
    mid();
    chk("rd_c_gnt", c_gnt, 1);
    chk("rd_m_rd", m_rd, 1);
    chk("rd_m_addr", m_addr, 12'h010);
    step();
    c_req = 0; m_rdata = 32'hDEADBEEF;
    mid();
    chk("rd_c_rvalid", c_rvalid, 1);
    chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("rd_d_rdata", d_rdata, 0);

    // Debug write, no core request.
    step();
    d_req = 1; d_we = 1; d_addr = 12'h100; d_wdata = 32'h12345678; d_funct3 = 3'd2;
    mid();
    chk("dw_d_gnt", d_gnt, 1);
    chk("dw_m_wr", m_wr, 1);
    chk("dw_m_addr", m_addr, 12'h100);
    chk("dw_m_wdata", m_wdata, 32'h12345678);
    step();
    d_req = 0;
    mid();
    chk("dw_no_rvalid", d_rvalid, 0);

    // Both reading continuously from reset: C,D,C,D...
    doReset();
    for (int i = 0; i < 6; i++) begin
      step();
      c_req = 1; c_we = 0; c_addr = 12'h020;
      d_req = 1; d_we = 0; d_addr = 12'h040; d_lock = 0;
      m_rdata = 32'hA0000000 + i;
      mid();
      chk("alt_c_gnt", c_gnt, (i % 2) == 0);
      chk("alt_d_gnt", d_gnt, (i % 2) == 1);
      chk("alt_c_rvalid", c_rvalid, i > 0 && (i % 2) == 1);
      chk("alt_d_rvalid", d_rvalid, i > 0 && (i % 2) == 0);
    end

    // Locked debug burst of 10 writes against a waiting core.
    doReset();
    dcount = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      c_req = 1; c_we = 1; c_addr = 12'h300; c_wdata = 32'h0C0C0C0C;
      d_req = (dcount < 10); d_we = 1; d_lock = 1;
      d_addr = AW'(12'h200 + 4 * dcount); d_wdata = dcount;
      mid();
      want_c = (i % 5) == 0;
      chk("burst_c_gnt", c_gnt, want_c);
      chk("burst_d_gnt", d_gnt, !want_c);
      chk("burst_stall", core_stall, !want_c);
      if (!want_c) dcount++;
    end
    step();
    d_req = 0; d_lock = 0;
    mid();
    chk("unlock_c_gnt", c_gnt, 0);
    step();
    mid();
    chk("after_unlock_c_gnt", c_gnt, 1);

    // Reset the cycle after a core read grant.
    doReset();
    step();
    c_req = 1; c_we = 0; c_addr = 12'h030; d_req = 0;
    mid();
    chk("rr_c_gnt", c_gnt, 1);
    step();
    n_rst = 0; c_req = 0;
    mid();
    chk("rr_cancel_rvalid", c_rvalid, 0);
    step();
    n_rst = 1; c_req = 1; d_req = 1; d_we = 0;
    mid();
    chk("rr_post_rvalid", c_rvalid, 0);
    chk("rr_first_core", c_gnt, 1);
    chk("rr_first_dbg", d_gnt, 0);

    for (int i = 0; i < 3000; i++) begin
      step();
      applyStimulus();
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
